// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Turns MemRead/MemWrite requests into handshaked transactions on a
// variable-latency data-memory port and stalls the pipeline until done.
//
// Parameters:
//   ACK_TIMEOUT  max REQ cycles without dm_ack before abandoning the access
//   CNT_W        timeout counter width, 2**CNT_W > ACK_TIMEOUT
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   MemRead_mem           load in MEM stage
//   MemWrite_mem          store in MEM stage (wins over MemRead_mem)
//   xfer_byte_mem         1 = byte access, 0 = doubleword
//   alu_result_mem        effective address
//   write_data_mem        store data (byte store uses [7:0])
//   stall_mem             hold IF..MEM stages and MEM/WB register
//   dm_read_data_mem      load result to MEM/WB
//   bus_error             one-cycle pulse: access abandoned on timeout
//   misalign_fault        one-cycle pulse: misaligned doubleword
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wmask   memory request port
//   dm_ack/dm_rdata       memory completion pulse and read data
//
// Build option: define MEM_ALIGN_CHECK_EN to reject doubleword accesses
// with addr[2:0] != 0 (no request issued, misalign_fault pulses).
// Without it misalign_fault is tied to 0.

module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic        xfer_byte_mem,
  input  logic [63:0] alu_result_mem,
  input  logic [63:0] write_data_mem,
  output logic        stall_mem,
  output logic [63:0] dm_read_data_mem,
  output logic        bus_error,
  output logic        misalign_fault,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  output logic [7:0]  dm_wmask,
  input  logic        dm_ack,
  input  logic [63:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_byte;
  logic             op;
  logic [2:0]       lane;
  logic [63:0]      read_result;

  assign op   = MemRead_mem | MemWrite_mem;
  assign lane = dm_addr[2:0];

  // Stall is combinational so the pipeline holds in the same cycle the
  // op is seen; forced low while reset is asserted.
  assign stall_mem = reset & (((state == IDLE) & op) | (state == REQ));

  assign read_result = is_byte ? {56'b0, dm_rdata[{lane, 3'b000} +: 8]} : dm_rdata;

`ifndef MEM_ALIGN_CHECK_EN
  assign misalign_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      is_byte          <= 1'b0;
      dm_req           <= 1'b0;
      dm_we            <= 1'b0;
      dm_addr          <= '0;
      dm_wdata         <= '0;
      dm_wmask         <= '0;
      dm_read_data_mem <= '0;
      bus_error        <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_fault   <= 1'b0;
`endif
    end else begin
      bus_error <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (op) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (!xfer_byte_mem && (alu_result_mem[2:0] != 3'b000)) begin
              misalign_fault <= 1'b1;
              state          <= DONE;
            end else
`endif
            begin
              dm_addr  <= alu_result_mem;
              dm_we    <= MemWrite_mem;
              is_byte  <= xfer_byte_mem;
              dm_wmask <= xfer_byte_mem ? (8'b1 << alu_result_mem[2:0]) : 8'hFF;
              dm_wdata <= xfer_byte_mem ? {8{write_data_mem[7:0]}} : write_data_mem;
              cnt      <= '0;
              dm_req   <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) dm_read_data_mem <= read_result;
            state  <= DONE;
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            dm_req           <= 1'b0;
            dm_read_data_mem <= '0;
            bus_error        <= 1'b1;
            state            <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit,
// built with ACK_TIMEOUT=4. Inputs change 1 ns after the rising edge;
// outputs are sampled there or 1 ns after an input change.

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_mem, MemWrite_mem, xfer_byte_mem;
  logic [63:0] alu_result_mem, write_data_mem;
  logic        stall_mem;
  logic [63:0] dm_read_data_mem;
  logic        bus_error, misalign_fault;
  logic        dm_req, dm_we;
  logic [63:0] dm_addr, dm_wdata;
  logic [7:0]  dm_wmask;
  logic        dm_ack;
  logic [63:0] dm_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned stall_cnt;
  int unsigned req_cnt;

  mem_access_unit #(.ACK_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
    .xfer_byte_mem(xfer_byte_mem), .alu_result_mem(alu_result_mem),
    .write_data_mem(write_data_mem), .stall_mem(stall_mem),
    .dm_read_data_mem(dm_read_data_mem), .bus_error(bus_error),
    .misalign_fault(misalign_fault), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Finish the current cycle: tally stall/req, then move to 1 ns past the next edge.
  task automatic tick();
    #1;
    if (stall_mem) stall_cnt++;
    if (dm_req) req_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead_mem = 1'b0; MemWrite_mem = 1'b0; xfer_byte_mem = 1'b0;
    dm_ack = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    alu_result_mem = '0; write_data_mem = '0; dm_rdata = '0;
    // Op asserted during reset must not stall.
    MemRead_mem = 1'b1;
    #12;
    check("rst_stall", 64'(stall_mem), 64'd0);
    check("rst_req", 64'(dm_req), 64'd0);
    check("rst_rdata", dm_read_data_mem, 64'd0);
    check("rst_wmask", 64'(dm_wmask), 64'd0);
    check("rst_flags", {62'd0, bus_error, misalign_fault}, 64'd0);
    MemRead_mem = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Doubleword load at 0x100, ack in the second REQ cycle.
    stall_cnt = 0;
    MemRead_mem = 1'b1; alu_result_mem = 64'h100;
    #1 check("ld_stall_idle", 64'(stall_mem), 64'd1);
    tick();
    check("ld_req", 64'(dm_req), 64'd1);
    check("ld_addr", dm_addr, 64'h100);
    check("ld_we", 64'(dm_we), 64'd0);
    check("ld_wmask", 64'(dm_wmask), 64'hFF);
    tick();
    dm_ack = 1'b1; dm_rdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    dm_ack = 1'b0; MemRead_mem = 1'b0;
    check("ld_data", dm_read_data_mem, 64'hDEADBEEF_CAFEF00D);
    check("ld_done_req", 64'(dm_req), 64'd0);
    check("ld_done_stall", 64'(stall_mem), 64'd0);
    check("ld_stall_cycles", 64'(stall_cnt), 64'd3);
    // dm_ack in DONE must be ignored.
    dm_ack = 1'b1; dm_rdata = 64'h1;
    tick();
    dm_ack = 1'b0;
    check("done_ack_ignored", dm_read_data_mem, 64'hDEADBEEF_CAFEF00D);
    check("idle_req", 64'(dm_req), 64'd0);

    // Byte store at 0x103 with MemRead also high (write wins).
    MemWrite_mem = 1'b1; MemRead_mem = 1'b1; xfer_byte_mem = 1'b1;
    alu_result_mem = 64'h103; write_data_mem = 64'h12345678_9ABCDEAB;
    tick();
    check("sb_we", 64'(dm_we), 64'd1);
    check("sb_wmask", 64'(dm_wmask), 64'h08);
    check("sb_wdata", dm_wdata, 64'hABABABAB_ABABABAB);
    check("sb_addr", dm_addr, 64'h103);
    dm_ack = 1'b1; dm_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle_inputs();
    check("sb_rdata_kept", dm_read_data_mem, 64'hDEADBEEF_CAFEF00D);
    tick();

    // Byte load at 0x105, 1-cycle ack.
    stall_cnt = 0;
    MemRead_mem = 1'b1; xfer_byte_mem = 1'b1; alu_result_mem = 64'h105;
    tick();
    check("lb_wmask", 64'(dm_wmask), 64'h20);
    dm_ack = 1'b1; dm_rdata = 64'h0011_2233_4455_6677;
    tick();
    idle_inputs();
    check("lb_data", dm_read_data_mem, 64'h22);
    check("lb_stall_cycles", 64'(stall_cnt), 64'd2);
    tick();

    // Doubleword store at 0x108.
    MemWrite_mem = 1'b1; alu_result_mem = 64'h108; write_data_mem = 64'h0102030405060708;
    tick();
    check("sd_wmask", 64'(dm_wmask), 64'hFF);
    check("sd_wdata", dm_wdata, 64'h0102030405060708);
    dm_ack = 1'b1;
    tick();
    idle_inputs();
    check("sd_rdata_kept", dm_read_data_mem, 64'h22);
    tick();

    // Timeout: no ack, request held exactly ACK_TIMEOUT cycles.
    MemRead_mem = 1'b1; alu_result_mem = 64'h200;
    tick();
    req_cnt = 0;
    for (int i = 0; i < 10 && dm_req; i++) tick();
    idle_inputs();
    check("to_req_cycles", 64'(req_cnt), 64'd4);
    check("to_bus_error", 64'(bus_error), 64'd1);
    check("to_rdata", dm_read_data_mem, 64'd0);
    check("to_stall", 64'(stall_mem), 64'd0);
    tick();
    check("to_bus_error_pulse", 64'(bus_error), 64'd0);
    MemRead_mem = 1'b1; alu_result_mem = 64'h208;
    #1 check("to_back_idle", 64'(stall_mem), 64'd1);
    MemRead_mem = 1'b0;
    tick();

    // Async reset in REQ.
    MemRead_mem = 1'b1; alu_result_mem = 64'h300;
    tick();
    check("ar_req_before", 64'(dm_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_req_async", 64'(dm_req), 64'd0);
    check("ar_stall_async", 64'(stall_mem), 64'd0);
    MemRead_mem = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check("ar_req_after", 64'(dm_req), 64'd0);
    check("ar_stall_after", 64'(stall_mem), 64'd0);
    check("ar_outs_zero", dm_addr | dm_wdata | dm_read_data_mem |
          64'({dm_we, dm_wmask, bus_error, misalign_fault}), 64'd0);

    // Misaligned doubleword load at 0x104.
    stall_cnt = 0; req_cnt = 0;
    MemRead_mem = 1'b1; xfer_byte_mem = 1'b0; alu_result_mem = 64'h104;
    dm_read_data_mem_pre: begin end
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    idle_inputs();
    check("ma_fault", 64'(misalign_fault), 64'd1);
    check("ma_no_req", 64'(dm_req), 64'd0);
    check("ma_stall_cycles", 64'(stall_cnt), 64'd1);
    check("ma_rdata_kept", dm_read_data_mem, 64'd0);
    tick();
    check("ma_fault_pulse", 64'(misalign_fault), 64'd0);
    check("ma_req_never", 64'(req_cnt), 64'd0);
`else
    check("ma_req", 64'(dm_req), 64'd1);
    check("ma_addr", dm_addr, 64'h104);
    check("ma_fault_tied", 64'(misalign_fault), 64'd0);
    dm_ack = 1'b1; dm_rdata = 64'h5555_6666_7777_8888;
    tick();
    idle_inputs();
    check("ma_data", dm_read_data_mem, 64'h5555_6666_7777_8888);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
